// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core: a FETCH/DECODE/EXEC sequencer with PC, IR, ACC, an ALU and {c,z} flags,
// talking to memory over separate address/read/write ports with a ready handshake for wait states.
module acc_cpu_core #(
   parameter  int WORD_W = 12,
   parameter  int OP_W   = 4,
   localparam int ADDR_W = WORD_W - OP_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [WORD_W-1:0] acc_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic [1:0]        flags,
   output logic              halted
);

   localparam logic [2:0] S_FETCH   = 3'd0;
   localparam logic [2:0] S_DECODE  = 3'd1;
   localparam logic [2:0] S_EXEC_RD = 3'd2;
   localparam logic [2:0] S_EXEC_WR = 3'd3;
   localparam logic [2:0] S_HALT    = 3'd4;

   localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_AND   = OP_W'(4);
   localparam logic [OP_W-1:0] OP_OR    = OP_W'(5);
   localparam logic [OP_W-1:0] OP_XOR   = OP_W'(6);
   localparam logic [OP_W-1:0] OP_LSL   = OP_W'(7);
   localparam logic [OP_W-1:0] OP_LSR   = OP_W'(8);
   localparam logic [OP_W-1:0] OP_JMP   = OP_W'(9);
   localparam logic [OP_W-1:0] OP_JZ    = OP_W'(10);
   localparam logic [OP_W-1:0] OP_JC    = OP_W'(11);
   localparam logic [OP_W-1:0] OP_LDI   = OP_W'(12);
   localparam logic [OP_W-1:0] OP_HALT  = OP_W'(15);

   logic [2:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [WORD_W-1:0] ir;
   logic [WORD_W-1:0] acc;
   logic              c_flag;
   logic              z_flag;

   logic [OP_W-1:0]   opcode;
   logic [ADDR_W-1:0] field;
   logic [WORD_W-1:0] field_ext;
   logic [WORD_W-1:0] shl;
   logic [WORD_W-1:0] shr;
   logic [WORD_W:0]   add_sum;
   logic [WORD_W-1:0] alu_res;
   logic              alu_c;

   assign opcode    = ir[WORD_W-1 -: OP_W];
   assign field     = ir[ADDR_W-1:0];
   assign field_ext = {{OP_W{1'b0}}, field};
   assign shl       = {acc[WORD_W-2:0], 1'b0};
   assign shr       = {1'b0, acc[WORD_W-1:1]};

   // Memory-operand ALU; carry only moves for ADD/SUB, other ops pass the old carry through.
   always_comb begin
      add_sum = {1'b0, acc} + {1'b0, mem_rdata};
      alu_res = mem_rdata;
      alu_c   = c_flag;
      case (opcode)
         OP_ADD: begin
            alu_res = add_sum[WORD_W-1:0];
            alu_c   = add_sum[WORD_W];
         end
         OP_SUB: begin
            alu_res = acc - mem_rdata;
            alu_c   = (acc < mem_rdata);
         end
         OP_AND:  alu_res = acc & mem_rdata;
         OP_OR:   alu_res = acc | mem_rdata;
         OP_XOR:  alu_res = acc ^ mem_rdata;
         default: alu_res = mem_rdata;
      endcase
   end

   // Requests are decoded from state alone and forced idle while reset is held.
   always_comb begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      halted = 1'b0;
      if (!reset) begin
         mem_rd = (state == S_FETCH) || (state == S_EXEC_RD);
         mem_wr = (state == S_EXEC_WR);
         halted = (state == S_HALT);
      end
   end

   assign mem_addr  = (state == S_FETCH) ? pc : field;
   assign mem_wdata = acc;
   assign acc_out   = acc;
   assign pc_out    = pc;
   assign flags     = {c_flag, z_flag};

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_FETCH;
         pc     <= '0;
         ir     <= '0;
         acc    <= '0;
         c_flag <= 1'b0;
         z_flag <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  ir    <= mem_rdata;
                  pc    <= pc + ADDR_W'(1);
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               state <= S_FETCH;
               case (opcode)
                  OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state <= S_EXEC_RD;
                  OP_STORE: state <= S_EXEC_WR;
                  OP_LSL: begin
                     acc    <= shl;
                     c_flag <= acc[WORD_W-1];
                     z_flag <= (shl == '0);
                  end
                  OP_LSR: begin
                     acc    <= shr;
                     c_flag <= acc[0];
                     z_flag <= (shr == '0);
                  end
                  OP_JMP: pc <= field;
                  OP_JZ:  if (z_flag) pc <= field;
                  OP_JC:  if (c_flag) pc <= field;
                  OP_LDI: begin
                     acc    <= field_ext;
                     z_flag <= (field == '0);
                  end
                  OP_HALT: state <= S_HALT;
                  default: ;
               endcase
            end
            S_EXEC_RD: begin
               if (mem_ready) begin
                  acc    <= alu_res;
                  c_flag <= alu_c;
                  z_flag <= (alu_res == '0);
                  state  <= S_FETCH;
               end
            end
            S_EXEC_WR: begin
               if (mem_ready) state <= S_FETCH;
            end
            S_HALT: state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: an instruction-level model predicts every bus transaction into a queue,
// and a monitor pops and compares each completed memory handshake; directed cases cover timing and reset.
module tb_acc_cpu_core;

   localparam int W    = 12;
   localparam int AW   = 8;
   localparam int MEMN = 256;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [W-1:0]  mem_rdata;
   logic          mem_ready = 1'b0;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_wdata;
   logic          mem_rd;
   logic          mem_wr;
   logic [W-1:0]  acc_out;
   logic [AW-1:0] pc_out;
   logic [1:0]    flags;
   logic          halted;

   logic [W-1:0]  mem [MEMN];

   assign mem_rdata = mem[mem_addr];

   always #5 clock = ~clock;

   acc_cpu_core #(.WORD_W(W), .OP_W(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .acc_out   (acc_out),
      .pc_out    (pc_out),
      .flags     (flags),
      .halted    (halted)
   );

   typedef struct {
      bit wr;
      bit fetch;
      int addr;
      int data;
      int flg;
   } txn_t;

   txn_t expq[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   rdy_mode = 0;   // 0: ready tied high, 1: random waits, 2: driven by the test
   int   m_pc, m_acc, m_c, m_z;
   bit   m_hlt;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic fill(input logic [W-1:0] v);
      for (int i = 0; i < MEMN; i++) mem[i] = v;
   endtask

   // Instruction-set model: executes up to max_ins instructions on a private copy of memory.
   task automatic model_run(input int max_ins);
      int m[MEMN];
      int ins, op, f, v, s;
      for (int i = 0; i < MEMN; i++) m[i] = int'(mem[i]);
      m_pc = 0; m_acc = 0; m_c = 0; m_z = 0; m_hlt = 1'b0;
      for (int k = 0; k < max_ins && !m_hlt; k++) begin
         expq.push_back('{wr:1'b0, fetch:1'b1, addr:m_pc, data:m_acc, flg:m_c*2+m_z});
         ins  = m[m_pc];
         m_pc = (m_pc + 1) % MEMN;
         op   = ins / 256;
         f    = ins % 256;
         case (op)
            0, 2, 3, 4, 5, 6: begin
               expq.push_back('{wr:1'b0, fetch:1'b0, addr:f, data:0, flg:0});
               v = m[f];
               case (op)
                  0: m_acc = v;
                  2: begin s = m_acc + v; m_c = (s >= 4096); m_acc = s % 4096; end
                  3: begin m_c = (m_acc < v); m_acc = (m_acc - v + 4096) % 4096; end
                  4: m_acc = m_acc & v;
                  5: m_acc = m_acc | v;
                  default: m_acc = m_acc ^ v;
               endcase
               m_z = (m_acc == 0);
            end
            1: begin
               expq.push_back('{wr:1'b1, fetch:1'b0, addr:f, data:m_acc, flg:0});
               m[f] = m_acc;
            end
            7:  begin m_c = m_acc / 2048; m_acc = (m_acc * 2) % 4096; m_z = (m_acc == 0); end
            8:  begin m_c = m_acc % 2; m_acc = m_acc / 2; m_z = (m_acc == 0); end
            9:  m_pc = f;
            10: if (m_z != 0) m_pc = f;
            11: if (m_c != 0) m_pc = f;
            12: begin m_acc = f; m_z = (f == 0); end
            15: m_hlt = 1'b1;
            default: ;
         endcase
      end
   endtask

   // Ready driver for the tied-high and random-wait modes.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (rdy_mode == 0) mem_ready = 1'b1;
         else if (rdy_mode == 1) mem_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: every completed handshake is one transaction; memory writes land here too.
   initial begin
      txn_t t;
      bit   ok;
      forever begin
         @(negedge clock);
         if (!reset && mem_ready && (mem_rd || mem_wr)) begin
            if (mem_wr) mem[mem_addr] = mem_wdata;
            if (expq.size() > 0) begin
               t  = expq.pop_front();
               ok = (mem_wr == t.wr) && (mem_rd == !t.wr) && (int'(mem_addr) == t.addr);
               if (t.wr) ok = ok && (int'(mem_wdata) == t.data);
               if (t.fetch) ok = ok && (int'(acc_out) == t.data) && (int'(flags) == t.flg);
               n_chk++;
               if (ok) n_pass++;
               else $display("FAIL bus_txn: got rd=%0d wr=%0d addr=0x%0h wdata=0x%0h acc=0x%0h flags=%0d, expected wr=%0d fetch=%0d addr=0x%0h data=0x%0h flags=%0d",
                             mem_rd, mem_wr, mem_addr, mem_wdata, acc_out, flags, t.wr, t.fetch, t.addr, t.data, t.flg);
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      expq.delete();
   endtask

   // Releases reset, runs the loaded program against the model and returns cycles until done.
   task automatic run_prog(input int k, input int mode, output int cyc);
      int bad;
      rdy_mode = mode;
      if (mode == 0) mem_ready = 1'b1;
      model_run(k);
      cyc = 0;
      reset = 1'b0;
      while (cyc < 4000) begin
         @(negedge clock);
         cyc++;
         if (m_hlt ? (halted === 1'b1) : (expq.size() == 0)) break;
      end
      chk(expq.size() == 0, "queue_drained", expq.size(), 0);
      if (m_hlt) begin
         chk(halted === 1'b1, "halted", int'(halted), 1);
         chk(int'(pc_out) == m_pc, "halt_pc", int'(pc_out), m_pc);
         chk(int'(acc_out) == m_acc, "halt_acc", int'(acc_out), m_acc);
         chk(int'(flags) == m_c*2+m_z, "halt_flags", int'(flags), m_c*2+m_z);
         bad = 0;
         repeat (20) begin
            @(negedge clock);
            if (mem_rd || mem_wr || !halted) bad++;
         end
         chk(bad == 0, "halt_quiet", bad, 0);
      end
   endtask

   initial begin
      int cyc, bad;

      // Reset state and a lone HALT
      fill(12'hD00);
      mem[0] = 12'hF00;
      do_reset();
      @(negedge clock);
      chk(!mem_rd && !mem_wr && !halted, "reset_ctrl", {mem_rd, mem_wr, halted}, 0);
      chk(pc_out == 0 && acc_out == 0 && flags == 0, "reset_regs", int'(acc_out), 0);
      @(posedge clock);
      #1;
      run_prog(50, 0, cyc);
      chk(cyc == 3, "halt_latency", cyc, 3);
      chk(pc_out == 8'h01, "halt_pc_one", int'(pc_out), 1);

      // LDI / ADD with carry out / STORE / HALT
      do_reset();
      fill(12'hD00);
      mem[0] = 12'hC05; mem[1] = 12'h280; mem[2] = 12'h181; mem[3] = 12'hF00;
      mem[8'h80] = 12'hFFB; mem[8'h81] = 12'h123;
      run_prog(50, 0, cyc);
      chk(cyc == 11, "add_prog_latency", cyc, 11);
      chk(mem[8'h81] == 12'h000, "store_data", int'(mem[8'h81]), 0);
      chk(flags == 2'b11, "add_flags", int'(flags), 3);
      chk(acc_out == 12'h000, "add_acc", int'(acc_out), 0);

      // SUB with borrow, JC taken, JZ not taken (random waits)
      do_reset();
      fill(12'hD00);
      mem[0] = 12'hC03; mem[1] = 12'h380; mem[2] = 12'hB40;
      mem[8'h40] = 12'hA10; mem[8'h41] = 12'hF00; mem[8'h80] = 12'h005;
      run_prog(50, 1, cyc);
      chk(acc_out == 12'hFFE, "sub_acc", int'(acc_out), 12'hFFE);
      chk(flags == 2'b10, "sub_flags", int'(flags), 2);
      chk(pc_out == 8'h42, "jump_pc", int'(pc_out), 8'h42);

      // Wait states on FETCH and EXEC_RD of a LOAD
      do_reset();
      fill(12'hD00);
      mem[0] = 12'h080; mem[8'h80] = 12'h5A5;
      rdy_mode = 2;
      mem_ready = 1'b0;
      reset = 1'b0;
      bad = 0;
      repeat (3) begin
         @(negedge clock);
         if (!(mem_rd && !mem_wr && mem_addr == 8'h00)) bad++;
      end
      @(negedge clock);
      if (!(mem_rd && mem_addr == 8'h00)) bad++;
      mem_ready = 1'b1;
      @(negedge clock);
      if (mem_rd || mem_wr) bad++;
      mem_ready = 1'b0;
      repeat (3) begin
         @(negedge clock);
         if (!(mem_rd && !mem_wr && mem_addr == 8'h80)) bad++;
      end
      @(negedge clock);
      if (!(mem_rd && mem_addr == 8'h80)) bad++;
      mem_ready = 1'b1;
      @(negedge clock);
      chk(bad == 0, "wait_hold", bad, 0);
      chk(mem_rd && mem_addr == 8'h01, "wait_next_fetch", int'(mem_addr), 1);
      chk(acc_out == 12'h5A5, "wait_load_acc", int'(acc_out), 12'h5A5);

      // Shifts into carry and PC wrap past 0xFF
      do_reset();
      fill(12'hD00);
      mem[0] = 12'hC80;
      for (int i = 1; i <= 5; i++) mem[i] = 12'h700;
      mem[6] = 12'h9FE; mem[8'hFE] = 12'h9FF; mem[8'hFF] = 12'hD00;
      run_prog(10, 1, cyc);

      // Reset while a write is stalled
      do_reset();
      fill(12'hD00);
      mem[0] = 12'hC07; mem[1] = 12'h181; mem[8'h81] = 12'hABC;
      rdy_mode = 2;
      mem_ready = 1'b1;
      reset = 1'b0;
      repeat (4) @(negedge clock);
      mem_ready = 1'b0;
      @(negedge clock);
      chk(mem_wr && !mem_rd && mem_addr == 8'h81 && mem_wdata == 12'h007, "exec_wr_req", int'(mem_wdata), 7);
      @(negedge clock);
      chk(mem_wr && mem_addr == 8'h81, "exec_wr_held", int'(mem_addr), 8'h81);
      reset = 1'b1;
      #1;
      chk(!mem_wr && !mem_rd, "wr_dropped_in_reset", int'(mem_wr), 0);
      @(negedge clock);
      chk(pc_out == 0 && acc_out == 0 && flags == 0, "reset_mid_wr_regs", int'(acc_out), 0);
      chk(!mem_wr && !mem_rd && !halted, "reset_mid_wr_ctrl", {mem_rd, mem_wr, halted}, 0);
      chk(mem[8'h81] == 12'hABC, "no_write_done", int'(mem[8'h81]), 12'hABC);
      @(posedge clock);
      #1 reset = 1'b0;
      mem_ready = 1'b1;
      @(negedge clock);
      chk(mem_rd && mem_addr == 8'h00, "refetch_zero", int'(mem_addr), 0);

      // Random programs with random wait states
      for (int r = 0; r < 25; r++) begin
         do_reset();
         for (int i = 0; i < MEMN; i++) mem[i] = W'($urandom_range(0, 4095));
         run_prog(40, 1, cyc);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
